msrv32_muldiv_unit: RTL and testbench
=====================================

// Module: msrv32_muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit, directly downstream of the integer register file.
//   Consumes the two read operands (rs_1/rs_2) for M-extension ops and returns a result plus a write request
//   to the stage-3 writeback path, which drives the register file's rd_addr_in/wr_en_in/rd_in.
//   One bit per cycle (shift-add multiply, restoring divide); busy_out stalls the pipeline while an op is in flight.
// PARAMETERS
//   XLEN  32  operand/result width; power of two >= 8. Iteration counter is $clog2(XLEN)+1 bits.
// PORTS
//   clk_in       in   1     clock; all state updates on rising edge
//   reset_in     in   1     synchronous, active-high reset
//   start_in     in   1     request new op; sampled only in IDLE
//   funct3_in    in   3     RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs_1_in      in   XLEN  operand 1 (multiplicand / dividend)
//   rs_2_in      in   XLEN  operand 2 (multiplier / divisor)
//   rd_addr_in   in   5     destination register of the op
//   flush_in     in   1     abort in-flight op; no writeback
//   busy_out     out  1     op in progress (CALC or DONE); upstream must hold the instruction
//   valid_out    out  1     one-cycle completion pulse; drives the register-file write enable
//   result_out   out  XLEN  result; held until the next completion
//   rd_addr_out  out  5     destination of result_out; held with it
// BEHAVIOUR
//   Reset: state=IDLE; busy_out=0, valid_out=0, result_out=0, rd_addr_out=0; counter and operand regs cleared.
//     Reset mid-op discards the op with no valid_out.
//   FSM: IDLE -> CALC -> DONE -> IDLE. busy_out=(state!=IDLE); valid_out=(state==DONE). Both are state decodes.
//   IDLE: start_in=1 and flush_in=0 at an edge latches funct3, rd, operand magnitudes and sign flags.
//     If the op is a special case -> DONE next with the special result. Otherwise -> CALC with counter=XLEN.
//   CALC: one iteration per cycle, counter decrements. When counter reaches 0 -> DONE. result_out and
//     rd_addr_out load on the CALC->DONE edge.
//   DONE: lasts exactly one cycle, then IDLE. start_in is ignored in CALC and DONE. A new start is
//     accepted in the IDLE cycle after DONE.
//   Latency: start sampled at edge of cycle T. Normal op: busy_out high T+1..T+XLEN+1, valid_out high only
//     in T+XLEN+1. Special case: busy_out and valid_out high in T+1 only.
//   Multiply: 2*XLEN-bit unsigned product of magnitudes, negated if the operand signs differ.
//     Signedness: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
//     MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
//   Divide: restoring division on magnitudes (DIV/REM signed; DIVU/REMU unsigned).
//     Quotient is negated if the signs differ; remainder takes the dividend's sign.
//   Special cases (all fast-path):
//     divisor==0 -> quotient all-ones, remainder = rs_1.
//     DIV/REM with rs_1 = 0x8000_0000 (most-negative XLEN value) and rs_2 = -1 -> quotient 0x8000_0000, remainder 0.
//   Multiply has no special cases; operands of 0 still take XLEN cycles.
//   flush_in=1 in CALC -> IDLE next edge, no valid_out; result_out and rd_addr_out unchanged.
//     flush_in in DONE does not retract valid_out; the state goes to IDLE as normal.
//     flush_in with start_in in IDLE -> start ignored.
//   rd_addr 0 is passed through unchanged; the register file suppresses the x0 write.
//   Operand inputs are sampled only at start; changes during CALC have no effect.
// TESTING
//   MUL: rs1=7, rs2=-3 (0xFFFF_FFFD) -> result 0xFFFF_FFEB.
//     valid_out exactly 33 cycles after start; busy_out high for those 33 cycles.
//   MULH: rs1=rs2=0x8000_0000 -> 0x4000_0000.
//     MULHU: 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
//     MULHSU: rs1=-1, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF.
//   DIV: -7 / 2 -> 0xFFFF_FFFD; REM: -7 % 2 -> 0xFFFF_FFFF; DIVU: 0xFFFF_FFFE / 2 -> 0x7FFF_FFFF.
//   DIV by 0 with rs1=-5 -> 0xFFFF_FFFF; REMU by 0 with rs1=9 -> 9.
//     DIV 0x8000_0000 / -1 -> 0x8000_0000.
//     Each special case: valid_out in the cycle after start, busy_out for 1 cycle.
//   Flush at CALC cycle 10 -> no valid_out and outputs unchanged.
//     Reset at cycle 5 -> all outputs 0 next cycle.
//     Then a new DIV completes correctly.
//   Back-to-back: start held high throughout -> ops complete every 34 cycles.
//     Operand changes during CALC are ignored.
//     rd_addr_out matches each op's rd.

Source files
------------

// File: rtl/msrv32_muldiv_unit_if.sv
// Operand/result bundle between the register-file read stage, the mul/div unit and stage-3 writeback.
// Master drives the request side; slave (the unit) drives status and result.
interface msrv32_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_in;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] rs_1_in;
    logic [XLEN-1:0] rs_2_in;
    logic [4:0]      rd_addr_in;
    logic            flush_in;
    logic            busy_out;
    logic            valid_out;
    logic [XLEN-1:0] result_out;
    logic [4:0]      rd_addr_out;

    modport master (
        output start_in, funct3_in, rs_1_in, rs_2_in, rd_addr_in, flush_in,
        input  busy_out, valid_out, result_out, rd_addr_out
    );

    modport slave (
        input  start_in, funct3_in, rs_1_in, rs_2_in, rd_addr_in, flush_in,
        output busy_out, valid_out, result_out, rd_addr_out
    );
endinterface

// File: rtl/msrv32_muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle (shift-add / restoring), XLEN+1 cycles per op,
// 1 cycle for divide special cases. busy_out holds the pipeline; start_in is only taken in IDLE.
module msrv32_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    msrv32_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;

    // Request decode (combinational, only consumed in IDLE)
    logic            s1_en, s2_en, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, min_val;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   hi_n, lo_n, quot, rem;
    logic [2*XLEN-1:0] prod, prod_f;

    always_comb begin
        min_val  = {1'b1, {(XLEN-1){1'b0}}};
        s1_en    = ~bus.funct3_in[0] | (bus.funct3_in[2:1] == 2'b00);
        s2_en    = (bus.funct3_in[2:1] == 2'b00) | (bus.funct3_in[2] & ~bus.funct3_in[0]);
        neg1     = s1_en & bus.rs_1_in[XLEN-1];
        neg2     = s2_en & bus.rs_2_in[XLEN-1];
        mag1     = neg1 ? -bus.rs_1_in : bus.rs_1_in;
        mag2     = neg2 ? -bus.rs_2_in : bus.rs_2_in;
        div_zero = bus.funct3_in[2] & (bus.rs_2_in == '0);
        div_ovf  = bus.funct3_in[2] & ~bus.funct3_in[0] &
                   (bus.rs_1_in == min_val) & (bus.rs_2_in == '1);
    end

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
        div_diff = {1'b0, hi_q, lo_q[XLEN-1]} - {2'b00, opa_q};
        if (f3_q[2]) begin
            // Borrow out means the shifted remainder is below the divisor: restore
            if (div_diff[XLEN+1]) begin
                hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_f = neg_q ? -prod : prod;
        quot   = neg_q ? -lo_n : lo_n;
        rem    = neg_rem_q ? -hi_n : hi_n;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opa_d     = opa_q;
        result_d  = result_q;
        rd_d      = rd_q;
        rd_out_d  = rd_out_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_in && !bus.flush_in) begin
                    f3_d      = bus.funct3_in;
                    rd_d      = bus.rd_addr_in;
                    neg_d     = neg1 ^ neg2;
                    neg_rem_d = neg1;
                    hi_d      = '0;
                    if (bus.funct3_in[2]) begin
                        opa_d = mag2;
                        lo_d  = mag1;
                    end else begin
                        opa_d = mag1;
                        lo_d  = mag2;
                    end
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        rd_out_d = bus.rd_addr_in;
                        if (div_zero)
                            result_d = bus.funct3_in[1] ? bus.rs_1_in : '1;
                        else
                            result_d = bus.funct3_in[1] ? '0 : bus.rs_1_in;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(XLEN);
                    end
                end
            end
            CALC: begin
                if (bus.flush_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d  = DONE;
                        rd_out_d = rd_q;
                        if (f3_q[2])
                            result_d = f3_q[1] ? rem : quot;
                        else
                            result_d = (f3_q[1:0] == 2'b00) ? prod_f[XLEN-1:0]
                                                             : prod_f[2*XLEN-1:XLEN];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opa_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            rd_out_q  <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opa_q     <= opa_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            rd_out_q  <= rd_out_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy_out    = (state_q != IDLE);
    assign bus.valid_out   = (state_q == DONE);
    assign bus.result_out  = result_q;
    assign bus.rd_addr_out = rd_out_q;
endmodule

// File: tb/tb_msrv32_muldiv_unit.sv
// Directed-vector bench for msrv32_muldiv_unit: results, latency, specials, flush, reset, back-to-back.
module tb_msrv32_muldiv_unit;
    logic clk_in = 1'b0;
    logic reset_in = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    msrv32_muldiv_unit_if #(.XLEN(32)) bus ();

    msrv32_muldiv_unit #(.XLEN(32)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Issue one op, scramble the operand inputs while it runs, then check latency/busy/result/rd.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        int n;
        logic busy_ok;
        bus.start_in   = 1'b1;
        bus.funct3_in  = f3;
        bus.rs_1_in    = a;
        bus.rs_2_in    = b;
        bus.rd_addr_in = rd;
        step();
        bus.start_in   = 1'b0;
        bus.rs_1_in    = ~a;
        bus.rs_2_in    = b ^ 32'h0000_0005;
        bus.rd_addr_in = ~rd;
        n = 1;
        busy_ok = 1'b1;
        while (!bus.valid_out && n < 100) begin
            if (!bus.busy_out) busy_ok = 1'b0;
            step();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy"}, {31'd0, busy_ok & bus.busy_out}, 32'd1);
        chk({tag, "_res"}, bus.result_out, exp);
        chk({tag, "_rd"}, {27'd0, bus.rd_addr_out}, {27'd0, rd});
        step();
        chk({tag, "_idle"}, {30'd0, bus.busy_out, bus.valid_out}, 32'd0);
    endtask

    initial begin : main
        int n;
        int t_prev;
        logic seen;
        logic [31:0] r_prev;
        logic [4:0]  rd_prev;
        logic [2:0]  bb_f3 [3];
        logic [31:0] bb_a  [3];
        logic [31:0] bb_b  [3];
        logic [4:0]  bb_rd [3];
        logic [31:0] bb_exp[3];

        bus.start_in = 1'b0; bus.funct3_in = 3'd0; bus.rs_1_in = '0; bus.rs_2_in = '0;
        bus.rd_addr_in = 5'd0; bus.flush_in = 1'b0;
        step(); step();
        reset_in = 1'b0;
        step();
        chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_res", bus.result_out, 32'd0);
        chk("rst_rd", {27'd0, bus.rd_addr_out}, 32'd0);

        do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD, 33);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, 33);
        do_op("divu",   3'b101, 32'hFFFF_FFFE, 32'd2,        5'd7,  32'h7FFF_FFFF, 33);
        do_op("div0",   3'b100, 32'hFFFF_FFFB, 32'd0,        5'd8,  32'hFFFF_FFFF, 1);
        do_op("remu0",  3'b111, 32'd9,        32'd0,        5'd9,  32'd9,         1);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);

        // start together with flush in IDLE is dropped
        bus.start_in = 1'b1; bus.flush_in = 1'b1; bus.funct3_in = 3'b000;
        step();
        bus.start_in = 1'b0; bus.flush_in = 1'b0;
        chk("flush_start_busy", {31'd0, bus.busy_out}, 32'd0);

        // Flush in CALC cycle 10
        r_prev = bus.result_out;
        rd_prev = bus.rd_addr_out;
        bus.start_in = 1'b1; bus.funct3_in = 3'b101; bus.rs_1_in = 32'd100;
        bus.rs_2_in = 32'd3; bus.rd_addr_in = 5'd12;
        step();
        bus.start_in = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.flush_in = 1'b1;
        step();
        bus.flush_in = 1'b0;
        chk("flush_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("flush_res", bus.result_out, r_prev);
        chk("flush_rd", {27'd0, bus.rd_addr_out}, {27'd0, rd_prev});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) seen = 1'b1;
            step();
        end
        chk("flush_novalid", {31'd0, seen}, 32'd0);

        // Reset at CALC cycle 5
        bus.start_in = 1'b1; bus.funct3_in = 3'b000; bus.rs_1_in = 32'd5;
        bus.rs_2_in = 32'd6; bus.rd_addr_in = 5'd13;
        step();
        bus.start_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk("mrst_out", {bus.busy_out, bus.valid_out, bus.rd_addr_out, 25'd0}, 32'd0);
        chk("mrst_res", bus.result_out, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) seen = 1'b1;
            step();
        end
        chk("mrst_novalid", {31'd0, seen}, 32'd0);
        do_op("div_after_rst", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, 33);

        // Back-to-back with start held high; next op's operands appear while the current one computes
        bb_f3[0] = 3'b000; bb_a[0] = 32'd7;         bb_b[0] = 32'hFFFF_FFFD; bb_rd[0] = 5'd20; bb_exp[0] = 32'hFFFF_FFEB;
        bb_f3[1] = 3'b101; bb_a[1] = 32'hFFFF_FFFE; bb_b[1] = 32'd2;         bb_rd[1] = 5'd0;  bb_exp[1] = 32'h7FFF_FFFF;
        bb_f3[2] = 3'b011; bb_a[2] = 32'hFFFF_FFFF; bb_b[2] = 32'hFFFF_FFFF; bb_rd[2] = 5'd31; bb_exp[2] = 32'hFFFF_FFFE;
        bus.start_in = 1'b1;
        bus.funct3_in = bb_f3[0]; bus.rs_1_in = bb_a[0]; bus.rs_2_in = bb_b[0]; bus.rd_addr_in = bb_rd[0];
        step();
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                bus.funct3_in = bb_f3[k+1]; bus.rs_1_in = bb_a[k+1];
                bus.rs_2_in = bb_b[k+1]; bus.rd_addr_in = bb_rd[k+1];
            end else begin
                bus.start_in = 1'b0;
            end
            n = 1;
            while (!bus.valid_out && n < 100) begin
                step();
                n++;
            end
            chk($sformatf("b2b%0d_lat", k), n, 33);
            chk($sformatf("b2b%0d_res", k), bus.result_out, bb_exp[k]);
            chk($sformatf("b2b%0d_rd", k), {27'd0, bus.rd_addr_out}, {27'd0, bb_rd[k]});
            if (k > 0) chk($sformatf("b2b%0d_gap", k), cyc - t_prev, 34);
            t_prev = cyc;
            step();
            chk($sformatf("b2b%0d_idle", k), {31'd0, bus.busy_out}, 32'd0);
            if (k < 2) step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
